// File: rtl/gray_stream_conv.sv
// Streaming gray<->binary converter: two-stage elastic pipeline with per-word mode,
// a gray adjacency checker on mode-0 input words and a saturating error counter.
module gray_stream_conv #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_mode,
    output logic             out_adj_err,
    output logic [CNT_W-1:0] err_cnt,
    input  logic             cnt_clr
);

    localparam int H = WIDTH / 2;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // S1 holds upper bits already converted, lower bits raw, plus raw bit H
    // which the binary->gray half in S2 still needs.
    typedef struct packed {
        logic             mode;
        logic             err;
        logic             bnd;
        logic [WIDTH-1:0] part;
    } s1_t;

    typedef struct packed {
        logic             mode;
        logic             err;
        logic [WIDTH-1:0] data;
    } s2_t;

    logic             s1_vld_q, s1_vld_d;
    logic             s2_vld_q, s2_vld_d;
    s1_t              s1_q, s1_d, s1_new;
    s2_t              s2_q, s2_d, s2_new;
    logic [WIDTH-1:0] ref_q, ref_d;
    logic             ref_vld_q, ref_vld_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             s2_adv, s1_adv, accept;
    logic [WIDTH-1:0] diff;
    logic             one_bit, adj_err;
    logic             acc_hi, acc_lo;
    logic [H:0]       low_raw;

    assign s2_adv   = !s2_vld_q || out_ready;
    assign s1_adv   = !s1_vld_q || s2_adv;
    assign in_ready = s1_adv;
    assign accept   = in_valid && in_ready;

    assign diff    = in_data ^ ref_q;
    assign one_bit = (diff != '0) && ((diff & (diff - {{(WIDTH-1){1'b0}}, 1'b1})) == '0);
    assign adj_err = !in_mode && ref_vld_q && !one_bit;

    always_comb begin
        s1_new      = '0;
        s1_new.mode = in_mode;
        s1_new.err  = adj_err;
        s1_new.bnd  = in_data[H];
        s1_new.part = in_data;
        acc_hi      = 1'b0;
        if (!in_mode) begin
            for (int i = WIDTH - 1; i >= H; i--) begin
                acc_hi         = acc_hi ^ in_data[i];
                s1_new.part[i] = acc_hi;
            end
        end else begin
            s1_new.part[WIDTH-1:H] = in_data[WIDTH-1:H] ^ (in_data[WIDTH-1:H] >> 1);
        end
    end

    always_comb begin
        s2_new      = '0;
        s2_new.mode = s1_q.mode;
        s2_new.err  = s1_q.err;
        s2_new.data = s1_q.part;
        low_raw     = {s1_q.bnd, s1_q.part[H-1:0]};
        acc_lo      = s1_q.part[H];
        if (!s1_q.mode) begin
            for (int i = H - 1; i >= 0; i--) begin
                acc_lo         = acc_lo ^ s1_q.part[i];
                s2_new.data[i] = acc_lo;
            end
        end else begin
            s2_new.data[H-1:0] = low_raw[H-1:0] ^ low_raw[H:1];
        end
    end

    always_comb begin
        s1_vld_d  = s1_vld_q;
        s1_d      = s1_q;
        s2_vld_d  = s2_vld_q;
        s2_d      = s2_q;
        ref_d     = ref_q;
        ref_vld_d = ref_vld_q;
        cnt_d     = cnt_q;
        if (s1_adv) begin
            s1_vld_d = accept;
            if (accept) s1_d = s1_new;
        end
        if (s2_adv) begin
            s2_vld_d = s1_vld_q;
            if (s1_vld_q) s2_d = s2_new;
        end
        // A mode-1 word breaks the gray sequence, so the next mode-0 word re-seeds.
        if (accept) begin
            if (in_mode) begin
                ref_vld_d = 1'b0;
            end else begin
                ref_d     = in_data;
                ref_vld_d = 1'b1;
            end
        end
        if (cnt_clr)                                     cnt_d = '0;
        else if (accept && adj_err && cnt_q != CNT_MAX)  cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_q  <= 1'b0;
            s1_q      <= '0;
            s2_vld_q  <= 1'b0;
            s2_q      <= '0;
            ref_q     <= '0;
            ref_vld_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            s1_vld_q  <= s1_vld_d;
            s1_q      <= s1_d;
            s2_vld_q  <= s2_vld_d;
            s2_q      <= s2_d;
            ref_q     <= ref_d;
            ref_vld_q <= ref_vld_d;
            cnt_q     <= cnt_d;
        end
    end

    assign out_valid   = s2_vld_q;
    assign out_data    = s2_q.data;
    assign out_mode    = s2_q.mode;
    assign out_adj_err = s2_q.err;
    assign err_cnt     = cnt_q;

endmodule

// File: tb/tb_gray_stream_conv.sv
// Directed bench for gray_stream_conv: vector table plus hand sequences for stall,
// clear priority, counter saturation and asynchronous reset.
module tb_gray_stream_conv;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0, in_mode = 1'b0, out_ready = 1'b1, cnt_clr = 1'b0;
    logic [3:0] in_data = '0;
    logic       in_ready, out_valid, out_mode, out_adj_err;
    logic [3:0] out_data;
    logic [7:0] err_cnt;
    logic       s_in_ready, s_out_valid, s_out_mode, s_out_adj_err;
    logic [3:0] s_out_data;
    logic [1:0] s_err_cnt;

    always #5 clk = ~clk;

    gray_stream_conv #(.WIDTH(4), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_mode(in_mode), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_mode(out_mode),
        .out_adj_err(out_adj_err), .err_cnt(err_cnt), .cnt_clr(cnt_clr)
    );

    gray_stream_conv #(.WIDTH(4), .CNT_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_data(in_data), .in_mode(in_mode), .out_valid(s_out_valid),
        .out_ready(out_ready), .out_data(s_out_data), .out_mode(s_out_mode),
        .out_adj_err(s_out_adj_err), .err_cnt(s_err_cnt), .cnt_clr(cnt_clr)
    );

    typedef struct {
        logic       mode;
        logic [3:0] din;
        logic [3:0] dout;
        logic       err;
        int         cnt;
    } vec_t;

    typedef struct {
        logic [3:0] data;
        logic       mode;
        logic       err;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       chk_e;
    int         nvec = 0, nerr = 0;
    logic       hold_vld = 1'b0;
    logic [3:0] hold_data;
    logic       hold_mode, hold_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: delivered words must match accepted order; stalled outputs must hold.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (hold_vld) begin
                chk("hold_data", 32'(out_data), 32'(hold_data));
                chk("hold_mode", 32'(out_mode), 32'(hold_mode));
                chk("hold_err", 32'(out_adj_err), 32'(hold_err));
            end
            if (out_ready) begin
                hold_vld = 1'b0;
                if (exp_q.size() == 0) begin
                    nvec++;
                    nerr++;
                    $display("FAIL extra_word: got %0h want none", out_data);
                end else begin
                    chk_e = exp_q.pop_front();
                    chk("out_data", 32'(out_data), 32'(chk_e.data));
                    chk("out_mode", 32'(out_mode), 32'(chk_e.mode));
                    chk("out_adj_err", 32'(out_adj_err), 32'(chk_e.err));
                end
            end else begin
                hold_vld  = 1'b1;
                hold_data = out_data;
                hold_mode = out_mode;
                hold_err  = out_adj_err;
            end
        end else begin
            hold_vld = 1'b0;
        end
    end

    // Leaves in_valid high so consecutive calls stream back-to-back.
    task automatic send(input logic m, input logic [3:0] d, input logic [3:0] ed, input logic ee);
        int   n = 0;
        exp_t e;
        in_valid = 1'b1;
        in_mode  = m;
        in_data  = d;
        if (clk) @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            nvec++;
            nerr++;
            $display("FAIL accept_timeout: got in_ready 0 want 1");
        end else begin
            e.data = ed;
            e.mode = m;
            e.err  = ee;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("drain_left", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1);
    end

    initial begin
        logic [3:0] gseq [16] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111,
                                  4'b0101, 4'b0100, 4'b1100, 4'b1101, 4'b1111, 4'b1110,
                                  4'b1010, 4'b1011, 4'b1001, 4'b1000};
        vec_t tbl[$];
        for (int i = 0; i < 16; i++) tbl.push_back('{1'b0, gseq[i], 4'(i), 1'b0, 0});
        tbl.push_back('{1'b1, 4'b1001, 4'b1101, 1'b0, 0});
        tbl.push_back('{1'b0, 4'b1101, 4'b1001, 1'b0, 0});
        tbl.push_back('{1'b1, 4'b0110, 4'b0101, 1'b0, 0});
        tbl.push_back('{1'b0, 4'b0110, 4'b0100, 1'b0, 0});
        tbl.push_back('{1'b1, 4'b1111, 4'b1000, 1'b0, 0});
        tbl.push_back('{1'b0, 4'b1000, 4'b1111, 1'b0, 0});
        tbl.push_back('{1'b1, 4'b0011, 4'b0010, 1'b0, 0});
        tbl.push_back('{1'b0, 4'b0011, 4'b0010, 1'b0, 0});
        tbl.push_back('{1'b0, 4'b0110, 4'b0100, 1'b1, 1});
        tbl.push_back('{1'b0, 4'b0110, 4'b0100, 1'b1, 2});

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_mode", 32'(out_mode), 32'd0);
        chk("rst_out_adj_err", 32'(out_adj_err), 32'd0);
        chk("rst_err_cnt", 32'(err_cnt), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // first edge after release accepts; out_valid two cycles later
        rst_n = 1'b1;
        send(1'b1, 4'b1001, 4'b1101, 1'b0);
        in_valid = 1'b0;
        @(negedge clk);
        chk("lat_one_cycle", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("lat_two_cycles", 32'(out_valid), 32'd1);

        foreach (tbl[i]) begin
            send(tbl[i].mode, tbl[i].din, tbl[i].dout, tbl[i].err);
            chk("tbl_err_cnt", 32'(err_cnt), 32'(tbl[i].cnt));
        end
        in_valid = 1'b0;
        drain();

        // clear coincident with a flagged acceptance
        cnt_clr = 1'b1;
        send(1'b0, 4'b0110, 4'b0100, 1'b1);
        in_valid = 1'b0;
        cnt_clr  = 1'b0;
        chk("clr_wins", 32'(err_cnt), 32'd0);
        chk("clr_wins_sat", 32'(s_err_cnt), 32'd0);

        // saturation on the CNT_W=2 instance
        for (int k = 1; k <= 5; k++) begin
            send(1'b0, 4'b0101, 4'b0110, 1'b1);
            chk("sat_wide_cnt", 32'(err_cnt), 32'(k));
            chk("sat_narrow_cnt", 32'(s_err_cnt), (k > 3) ? 32'd3 : 32'(k));
        end
        in_valid = 1'b0;
        drain();

        // downstream stall for 5 cycles
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        fork
            begin
                send(1'b1, 4'b0001, 4'b0001, 1'b0);
                send(1'b1, 4'b0010, 4'b0011, 1'b0);
                send(1'b1, 4'b0100, 4'b0110, 1'b0);
                send(1'b1, 4'b1000, 4'b1100, 1'b0);
                in_valid = 1'b0;
            end
            begin
                @(posedge clk);
                @(posedge clk);
                @(negedge clk);
                chk("stall_in_ready", 32'(in_ready), 32'd0);
                repeat (3) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // asynchronous reset with two words in flight
        send(1'b0, 4'b0100, 4'b0111, 1'b0);
        send(1'b0, 4'b1100, 4'b1000, 1'b0);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        chk("async_rst_out_valid", 32'(out_valid), 32'd0);
        chk("async_rst_in_ready", 32'(in_ready), 32'd1);
        chk("async_rst_err_cnt", 32'(err_cnt), 32'd0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        send(1'b0, 4'b1100, 4'b1000, 1'b0);
        in_valid = 1'b0;
        chk("post_rst_err_cnt", 32'(err_cnt), 32'd0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/gray_stream_conv.md
GRAY_STREAM_CONV -- requirements
Module: gray_stream_conv

Interface
REQ-001 SHALL have parameter WIDTH, default 4, data word width (legal range 2..32).
REQ-002 SHALL have parameter CNT_W, default 8, width of error counter.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  upstream word present.
REQ-006 SHALL have port in_ready  output  1  block accepts word this cycle.
REQ-007 SHALL have port in_data  input  WIDTH  word to convert.
REQ-008 SHALL have port in_mode  input  1  0 = gray->binary, 1 = binary->gray; sampled with in_data.
REQ-009 SHALL have port out_valid  output  1  converted word present.
REQ-010 SHALL have port out_ready  input  1  downstream accepts word.
REQ-011 SHALL have port out_data  output  WIDTH  converted word.
REQ-012 SHALL have port out_mode  output  1  mode the word was converted with.
REQ-013 SHALL have port out_adj_err  output  1  gray adjacency violation flag for this word.
REQ-014 SHALL have port err_cnt  output  CNT_W  count of adjacency violations.
REQ-015 SHALL have port cnt_clr  input  1  synchronous clear of err_cnt.

Function
REQ-016 SHALL accept a word when in_valid && in_ready; SHALL deliver a word when out_valid && out_ready.
REQ-017 SHALL implement two register stages (S1, S2); unstalled latency SHALL be exactly 2 cycles from acceptance to out_valid.
REQ-018 SHALL advance S2 when S2 empty or out_ready; S1 SHALL advance when S1 empty or S2 advances; in_ready = !S1_valid || !S2_valid || out_ready.
REQ-019 SHALL sustain one word per cycle with out_ready held high; SHALL never drop, duplicate or reorder words.
REQ-020 SHALL hold out_data/out_mode/out_adj_err stable while out_valid && !out_ready.
REQ-021 Mode 0: out_data[WIDTH-1] = in[WIDTH-1]; out_data[i] = out_data[i+1] ^ in[i] for i below MSB.
REQ-022 Mode 1: out_data = in ^ (in >> 1).
REQ-023 Conversion SHALL be split across S1 (upper half of XOR chain) and S2 (lower half); result SHALL equal REQ-021/022 for all WIDTH.
REQ-024 Adjacency check SHALL apply only to mode-0 words: flag set when accepted gray word differs from previous accepted mode-0 word in other than exactly one bit.
REQ-025 First mode-0 word after reset, and first mode-0 word following any accepted mode-1 word, SHALL not be checked (flag 0); this word becomes the new reference.
REQ-026 Repeated identical gray word (0 bits differ) SHALL flag an error.
REQ-027 Mode-1 words SHALL always carry out_adj_err = 0 and SHALL not update the reference.
REQ-028 err_cnt SHALL increment by 1 in the cycle a flagged word is accepted, saturating at 2^CNT_W-1.
REQ-029 cnt_clr SHALL force err_cnt to 0 next edge; cnt_clr coincident with a flagged acceptance SHALL yield 0 (clear wins).
REQ-030 Mode SHALL be switchable word-by-word without bubbles.

Reset
REQ-031 rst_n low SHALL asynchronously force S1/S2 valid to 0, out_valid = 0, out_data = 0, out_mode = 0, out_adj_err = 0, err_cnt = 0, reference-valid = 0.
REQ-032 in_ready SHALL be 1 during and after reset; words in flight at reset SHALL be discarded.
REQ-033 After rst_n deasserts, first acceptance SHALL be possible on the first rising edge.

Verification
REQ-034 WIDTH=4, mode 0, stream 0000,0001,0011,0010,0110,0111,0101,0100,1100,1101,1111,1110,1010,1011,1001,1000 back-to-back, out_ready=1 -> out_data 0..15 in order, out_valid from cycle 2, no errors, err_cnt=0.
REQ-035 Mode 1, in_data 1001 -> out_data 1101; mode 0, 1101 -> 1001; alternating modes back-to-back -> correct results, no bubbles.
REQ-036 Mode 0 sequence 0011 then 0110 -> second word out_adj_err=1, err_cnt=1; then 0110 again -> err, err_cnt=2; cnt_clr pulse -> err_cnt=0.
REQ-037 out_ready low 5 cycles with in_valid high -> in_ready drops after 2 words buffered, out_data held stable, all words delivered in order after release.
REQ-038 rst_n asserted asynchronously mid-stream with 2 words in flight -> out_valid=0 immediately, in-flight words lost, next mode-0 word unchecked.
REQ-039 CNT_W=2, 5 consecutive violations -> err_cnt saturates at 3.
